sine_range_reduce: RTL and testbench
====================================

# sine_range_reduce

Upstream argument-reduction stage for `sine_taylor_shell`.
- Accepts an unsigned angle in Q4.8 radians (0 … 15.996) through a valid/ready handshake.
- Reduces the angle iteratively to [0, π/2] and emits that value in Q4.8, plus a sign flag.
- The downstream Taylor stage evaluates sin of the reduced value; the consumer negates the result when the flag is set.
- Keeps the Taylor stage inside its accurate range without a divider.

## Interface
- `INT_BITS_I`, 12, angle width. Format is Q4.8 and is fixed by the package constants.
- `clk_rr_i`  in  1  single clock; all logic on the rising edge.
- `srst_rr_i`  in  1  reset; synchronous, active-high.
- `x_rr_i`  in  12  input angle, unsigned Q4.8.
- `valid_rr_i`  in  1  `x_rr_i` is valid.
- `ready_rr_o`  out  1  block can accept an input; high only in IDLE.
- `x_rr_o`  out  12  reduced angle, Q4.8, range 0 … 402.
- `neg_rr_o`  out  1  the sine of the original angle is minus the sine of `x_rr_o`.
- `valid_rr_o`  out  1  `x_rr_o` / `neg_rr_o` are valid.
- `ready_rr_i`  in  1  downstream accepts the output.

## Operation
- Constants, Q4.8 integer codes: TWO_PI = 1608, PI = 804, HALF_PI = 402.
- Internal accumulator `acc` is 13 bits wide.
- FSM states:
  - **IDLE**
    - `ready_rr_o` = 1.
    - On `valid_rr_i & ready_rr_o`: `acc` ← zero-extended `x_rr_i`, `neg` ← 0, go to REDUCE.
  - **REDUCE**
    - If `acc ≥ TWO_PI`: `acc` ← `acc − TWO_PI`, stay in REDUCE.
    - Otherwise go to FOLD.
    - At most 2 subtractions for a 12-bit input; 3 with the cosine option.
  - **FOLD**, single cycle:
    - If `acc ≥ PI`: `a` = `acc − PI` and `neg` ← 1.
    - Otherwise: `a` = `acc`.
    - If `a > HALF_PI`: `acc` ← `PI − a`. Otherwise: `acc` ← `a`.
    - Go to DONE.
  - **DONE**
    - `valid_rr_o` = 1; `x_rr_o` = `acc[11:0]`; `neg_rr_o` = `neg`.
    - On `ready_rr_i`: go to IDLE.
- Outputs are registered and held stable while `valid_rr_o & !ready_rr_i`.
- `valid_rr_i` outside IDLE is ignored and the input is not captured. The upstream must hold its data until it sees `ready_rr_o`.
- Rounding of the constants gives up to 1 LSB of error; no correction is applied.

## Timing
- Reset values: `ready_rr_o` = 1, `valid_rr_o` = 0, `x_rr_o` = 0, `neg_rr_o` = 0, state = IDLE, `acc` = 0.
- Reset in any state aborts the operation; the transaction in flight is discarded with no output.
- Latency:
  - Let k = number of subtractions.
  - `valid_rr_o` rises k+2 cycles after the accept edge.
  - Range is 2 … 4 cycles; 5 with the cosine option.
- Back-to-back operation:
  - `ready_rr_o` returns high on the cycle after the output handshake.
  - There is no accept in the same cycle as an output handshake.
  - Minimum issue interval is k+4 cycles.
- Boundary cases:
  - `acc == TWO_PI`: subtract.
  - `acc == PI`: fold gives 0 with neg = 1.
  - `a == HALF_PI`: not mirrored.
  - x = 0 gives 0, neg 0.

## Configuration
- Macro: `SINE_RR_COS_EN`.
- With the macro defined:
  - Adds input `cos_rr_i` (1 bit), sampled together with `x_rr_i`.
  - If `cos_rr_i` = 1, IDLE loads `acc` ← `x_rr_i + HALF_PI`, so the pipeline produces cos(x).
  - The 13-bit `acc` holds the maximum value 4497.
- Without the macro: the port is absent and the load is always `x_rr_i`.

## Structure
- Package `sine_pkg`:
  - Constants TWO_PI, PI, HALF_PI.
  - Q4.8 width constants.
  - State enum IDLE/REDUCE/FOLD/DONE.
- The package is shared with `sine_taylor_shell` and its bench.
- One combinational sub-module, `sine_rr_fold`:
  - Input: `acc` (13 bits).
  - Outputs: folded 12-bit value and the neg bit.
  - Used in the FOLD state; unit-testable on its own.

## Test plan
- Reset, then x = 384 (1.5), downstream ready = 1:
  - x_rr_o = 384, neg = 0.
  - valid rises 2 cycles after accept.
- x = 1600 (6.25):
  - x_rr_o = 8, neg = 1, latency 2.
- x = 4095:
  - Two subtractions, x_rr_o = 75, neg = 1.
  - valid rises 4 cycles after accept.
- x = 640 (2.5):
  - x_rr_o = 164, neg = 0.
  - Hold `ready_rr_i` = 0 for 5 cycles: outputs stay stable and `ready_rr_o` stays 0.
  - Input pulses during the wait are ignored.
- Assert `srst_rr_i` in REDUCE while processing x = 4095:
  - Next cycle all outputs are at reset values.
  - A following x = 384 returns 384 / 0.
- With `SINE_RR_COS_EN`, x = 0, cos = 1:
  - x_rr_o = 402, neg = 0.
  - x = 804, cos = 1 gives x_rr_o = 402, neg = 1.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared Q4.8 constants and FSM states for the sine range reducer and Taylor shell.
package sine_pkg;

  localparam int Q_INT  = 4;
  localparam int Q_FRAC = 8;
  localparam int Q_W    = Q_INT + Q_FRAC;
  localparam int ACC_W  = Q_W + 1;

  localparam logic [ACC_W-1:0] TWO_PI  = 13'd1608;
  localparam logic [ACC_W-1:0] PI      = 13'd804;
  localparam logic [ACC_W-1:0] HALF_PI = 13'd402;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FOLD,
    DONE
  } rr_state_t;

endpackage

// File: rtl/sine_rr_fold.sv
// Folds an angle in [0, 2pi) onto [0, pi/2] plus a negate flag.
module sine_rr_fold
  import sine_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  output logic [Q_W-1:0]   x_fold,
  output logic             neg_fold
);

  logic [ACC_W-1:0] a;

  always_comb begin
    neg_fold = (acc >= PI);
    a        = neg_fold ? acc - PI : acc;
    // mirror about pi/2; exactly pi/2 stays put
    x_fold   = (a > HALF_PI) ? Q_W'(PI - a) : Q_W'(a);
  end

endmodule

// File: rtl/sine_range_reduce.sv
// Iterative argument reduction to [0, pi/2] with sign flag.
// Define SINE_RR_COS_EN to add cos_rr_i (pre-offset by pi/2).
module sine_range_reduce
  import sine_pkg::*;
#(
  parameter int INT_BITS_I = 12
) (
  input  logic                  clk_rr_i,
  input  logic                  srst_rr_i,
  input  logic [INT_BITS_I-1:0] x_rr_i,
  input  logic                  valid_rr_i,
`ifdef SINE_RR_COS_EN
  input  logic                  cos_rr_i,
`endif
  output logic                  ready_rr_o,
  output logic [INT_BITS_I-1:0] x_rr_o,
  output logic                  neg_rr_o,
  output logic                  valid_rr_o,
  input  logic                  ready_rr_i
);

  rr_state_t        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [ACC_W-1:0] load;
  logic [Q_W-1:0]   fold_x;
  logic             fold_neg;

`ifdef SINE_RR_COS_EN
  assign load = ACC_W'(x_rr_i) + (cos_rr_i ? HALF_PI : '0);
`else
  assign load = ACC_W'(x_rr_i);
`endif

  sine_rr_fold u_fold (
    .acc      (acc_q),
    .x_fold   (fold_x),
    .neg_fold (fold_neg)
  );

  always_ff @(posedge clk_rr_i) begin
    if (srst_rr_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (valid_rr_i) begin
          acc_d   = load;
          neg_d   = 1'b0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (acc_q >= TWO_PI) acc_d = acc_q - TWO_PI;
        else                 state_d = FOLD;
      end
      FOLD: begin
        acc_d   = ACC_W'(fold_x);
        neg_d   = fold_neg;
        state_d = DONE;
      end
      DONE: begin
        if (ready_rr_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_rr_o = (state_q == IDLE);
  assign valid_rr_o = (state_q == DONE);
  assign x_rr_o     = acc_q[INT_BITS_I-1:0];
  assign neg_rr_o   = neg_q;

endmodule

// File: tb/tb_sine_range_reduce.sv
// Directed scoreboard bench for sine_range_reduce.
module tb_sine_range_reduce;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [11:0] x_in = '0;
  logic        valid_in = 1'b0;
  logic        cos_in = 1'b0;
  logic        ready_out;
  logic [11:0] x_out;
  logic        neg_out;
  logic        valid_out;
  logic        ready_in = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    bit neg;
    int lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sine_range_reduce #(.INT_BITS_I(12)) dut (
    .clk_rr_i   (clk),
    .srst_rr_i  (srst),
    .x_rr_i     (x_in),
    .valid_rr_i (valid_in),
`ifdef SINE_RR_COS_EN
    .cos_rr_i   (cos_in),
`endif
    .ready_rr_o (ready_out),
    .x_rr_o     (x_out),
    .neg_rr_o   (neg_out),
    .valid_rr_o (valid_out),
    .ready_rr_i (ready_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int x, input bit c, input int ex,
                       input bit en, input int el);
    int n;
    exp_t e;
    n = 0;
    while (!ready_out && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", {31'b0, ready_out}, 32'd1);
    x_in     = 12'(x);
    cos_in   = c;
    valid_in = 1'b1;
    e.x = ex;
    e.neg = en;
    e.lat = el;
    sb.push_back(e);
    tick();
    valid_in = 1'b0;
    cos_in   = 1'b0;
  endtask

  task automatic collect(input string tag);
    int lat;
    exp_t e;
    lat = 0;
    while (!valid_out && lat < 20) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_x"}, 32'(x_out), 32'(e.x));
      check({tag, "_neg"}, {31'b0, neg_out}, {31'b0, e.neg});
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_busy"}, {31'b0, ready_out}, 32'd0);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", {31'b0, ready_out}, 32'd1);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_neg", {31'b0, neg_out}, 32'd0);
    srst = 1'b0;
    tick();

    issue(384, 1'b0, 384, 1'b0, 2);
    collect("x384");
    tick();
    check("x384_ready_back", {31'b0, ready_out}, 32'd1);
    check("x384_valid_drop", {31'b0, valid_out}, 32'd0);

    issue(1600, 1'b0, 8, 1'b1, 2);
    collect("x1600");
    tick();

    issue(4095, 1'b0, 75, 1'b1, 4);
    collect("x4095");
    tick();

    ready_in = 1'b0;
    issue(640, 1'b0, 164, 1'b0, 2);
    collect("x640");
    for (int i = 0; i < 5; i++) begin
      x_in     = 12'd100;
      valid_in = (i % 2 == 0);
      tick();
      check("hold_x", 32'(x_out), 32'd164);
      check("hold_valid", {31'b0, valid_out}, 32'd1);
      check("hold_ready", {31'b0, ready_out}, 32'd0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    check("hold_release_valid", {31'b0, valid_out}, 32'd0);
    check("hold_release_ready", {31'b0, ready_out}, 32'd1);
    tick();
    check("no_stray_accept", {31'b0, ready_out}, 32'd1);

    issue(4095, 1'b0, 75, 1'b1, 4);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    void'(sb.pop_back());
    check("abort_ready", {31'b0, ready_out}, 32'd1);
    check("abort_valid", {31'b0, valid_out}, 32'd0);
    check("abort_x", 32'(x_out), 32'd0);
    check("abort_neg", {31'b0, neg_out}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_quiet", {31'b0, valid_out}, 32'd0);
    end

    issue(384, 1'b0, 384, 1'b0, 2);
    collect("post_rst");
    tick();

    issue(804, 1'b0, 0, 1'b1, 2);
    collect("x_pi");
    tick();

    issue(0, 1'b0, 0, 1'b0, 2);
    collect("x_zero");
    tick();

`ifdef SINE_RR_COS_EN
    issue(0, 1'b1, 402, 1'b0, 2);
    collect("cos0");
    tick();
    issue(804, 1'b1, 402, 1'b1, 2);
    collect("cos_pi");
    tick();
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
